// File: rtl/cgra_tile_dma_if.sv
// Signal bundle between the tile DMA, its command/stream users and the tile memory ext_* port.
// valid/ready: a word moves on each rising clk edge where both are high; the source holds valid and payload steady until then.
interface cgra_tile_dma_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [1:0]            cmd_bank;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  abort;

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_bank_sel;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  logic                  busy;
  logic                  done;
  logic                  done_aborted;

  modport master (
    input  cmd_valid, cmd_dir, cmd_bank, cmd_addr, cmd_len, abort,
    input  s_valid, s_data, m_ready, mem_rdata, mem_valid,
    output cmd_ready, s_ready, m_valid, m_data,
    output mem_addr, mem_bank_sel, mem_read, mem_write, mem_wdata,
    output busy, done, done_aborted
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_bank, cmd_addr, cmd_len, abort,
    output s_valid, s_data, m_ready, mem_rdata, mem_valid,
    input  cmd_ready, s_ready, m_valid, m_data,
    input  mem_addr, mem_bank_sel, mem_read, mem_write, mem_wdata,
    input  busy, done, done_aborted
  );
endinterface

// File: rtl/cgra_tile_dma.sv
// Tile DMA: LOAD streams words into one memory bank, STORE streams a bank out through a
// credit-controlled FIFO that hides the 1-cycle read latency and downstream backpressure.
module cgra_tile_dma #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_DEPTH = 1024,
  parameter int LEN_WIDTH  = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cgra_tile_dma_if.master bus,
  output logic [2:0]      dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]            bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  inflight_q;
  logic                  aborted_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic                  accept, load_hs, issue, abort_hit, push, pop;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [CRD_W-1:0]      credit_used;

  logic                  cmd_ready_c, s_ready_c, mem_read_c, mem_write_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [1:0]            mem_bank_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  assign addr_inc    = (addr_q == ADDR_WIDTH'(BANK_DEPTH - 1)) ? '0 : addr_q + 1'b1;
  // FIFO occupancy plus the read still on its way must leave room for one more word.
  assign credit_used = CRD_W'(fifo_count) + CRD_W'(inflight_q);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    load_hs     = 1'b0;
    issue       = 1'b0;
    abort_hit   = 1'b0;
    cmd_ready_c = 1'b0;
    s_ready_c   = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = '0;
    mem_bank_c  = '0;
    mem_wdata_c = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_len == '0) state_nxt = ST_DONE;
          else                   state_nxt = bus.cmd_dir ? ST_STORE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready_c   = 1'b1;
        load_hs     = bus.s_valid;
        mem_write_c = bus.s_valid;
        mem_wdata_c = bus.s_data;
        mem_addr_c  = addr_q;
        mem_bank_c  = bank_q;
        if (bus.abort) begin
          abort_hit = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (load_hs && remaining_q == LEN_WIDTH'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_STORE: begin
        issue      = (remaining_q != '0) && (credit_used < CRD_W'(FIFO_DEPTH));
        mem_read_c = issue;
        mem_addr_c = addr_q;
        mem_bank_c = bank_q;
        if (bus.abort) begin
          abort_hit = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (issue && remaining_q == LEN_WIDTH'(1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_count == '0) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        bank_q      <= bus.cmd_bank;
        addr_q      <= bus.cmd_addr;
        remaining_q <= bus.cmd_len;
        aborted_q   <= 1'b0;
      end else if (load_hs || issue) begin
        addr_q      <= addr_inc;
        remaining_q <= remaining_q - 1'b1;
      end
      if (abort_hit) aborted_q <= 1'b1;
    end
  end

  // Once aborted, the returning read is dropped rather than pushed.
  assign push = inflight_q && bus.mem_valid && !aborted_q;
  assign pop  = (fifo_count != '0) && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort_hit) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_c;
  assign bus.s_ready      = s_ready_c;
  assign bus.m_valid      = (fifo_count != '0);
  assign bus.m_data       = fifo_mem[rd_ptr];
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_bank_sel = mem_bank_c;
  assign bus.mem_read     = mem_read_c;
  assign bus.mem_write    = mem_write_c;
  assign bus.mem_wdata    = mem_wdata_c;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.done_aborted = (state == ST_DONE) && aborted_q;
  assign dbg_state        = state;
endmodule

// File: tb/tb_cgra_tile_dma.sv
// Bench for cgra_tile_dma: a bank-array memory model, expected-queue scoreboard for writes,
// reads, output words and done pulses, plus directed timing checks and a random command mix.
module tb_cgra_tile_dma;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int LW = 13;
  localparam int BD = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  cgra_tile_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  cgra_tile_dma #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_DEPTH(BD), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int reads_seen = 0;
  bit rand_ready = 1'b0;
  bit m_ready_force = 1'b0;

  logic [DW-1:0] ref_mem [4*BD];
  logic [DW-1:0] env_mem [4*BD];

  logic [29:0]   exp_wr_q[$];
  logic [13:0]   exp_rd_q[$];
  logic [DW-1:0] exp_m_q[$];
  logic [0:0]    exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Tile memory model: 1-cycle read latency; reloaded from the reference image during reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4*BD; i++) env_mem[i] <= ref_mem[i];
      bus.mem_valid <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_valid <= bus.mem_read;
      if (bus.mem_read)  bus.mem_rdata <= env_mem[{bus.mem_bank_sel, bus.mem_addr[9:0]}];
      if (bus.mem_write) env_mem[{bus.mem_bank_sel, bus.mem_addr[9:0]}] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : m_ready_force;
  end

  // Monitor: every DUT-side event is popped against the queues filled by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_read && bus.mem_write) unexpected("read_and_write", 32'h3);
      if (bus.mem_write) begin
        if (exp_wr_q.size() == 0) unexpected("write", {bus.mem_bank_sel, bus.mem_addr, bus.mem_wdata});
        else check("write", {bus.mem_bank_sel, bus.mem_addr, bus.mem_wdata}, 32'(exp_wr_q.pop_front()));
      end
      if (bus.mem_read) begin
        reads_seen++;
        if (exp_rd_q.size() == 0) unexpected("read", {bus.mem_bank_sel, bus.mem_addr});
        else check("read", {bus.mem_bank_sel, bus.mem_addr}, 32'(exp_rd_q.pop_front()));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_m_q.size() == 0) unexpected("m_data", 32'(bus.m_data));
        else check("m_data", 32'(bus.m_data), 32'(exp_m_q.pop_front()));
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) unexpected("done", 32'(bus.done_aborted));
        else check("done_aborted", 32'(bus.done_aborted), 32'(exp_done_q.pop_front()));
      end else if (bus.done_aborted) begin
        unexpected("done_aborted_alone", 32'h1);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input bit dir, input logic [1:0] bank, input int addr, input int len);
    int t = 0;
    while (!bus.cmd_ready && t < 200) begin
      cyc();
      t++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_bank  = bank;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = LW'(len);
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_words(input logic [1:0] bank, input int addr, input int n, input bit gaps,
                            input bit seq, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      int a;
      d = seq ? DW'(base + i*step) : DW'($urandom);
      a = (addr + i) % BD;
      if (gaps) begin
        bus.s_valid = 1'b0;
        cyc($urandom_range(0, 2));
      end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      exp_wr_q.push_back({bank, AW'(a), d});
      ref_mem[bank*BD + a] = d;
      cyc();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic expect_store(input logic [1:0] bank, input int addr, input int n_rd, input int n_m);
    for (int i = 0; i < n_rd; i++) exp_rd_q.push_back({bank, AW'((addr + i) % BD)});
    for (int i = 0; i < n_m; i++) exp_m_q.push_back(ref_mem[bank*BD + (addr + i) % BD]);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 500) begin
      cyc();
      t++;
    end
    check("busy_after_burst", 32'(bus.busy), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_mem_rw"}, {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'h0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'h0);
    check({tag, "_done"}, {30'h0, bus.done, bus.done_aborted}, 32'h0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_bank  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    for (int i = 0; i < 4*BD; i++) ref_mem[i] = DW'($urandom);

    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // LOAD bank 2 @0x010, four back-to-back words 0xA0..0xA3
    exp_done_q.push_back(1'b0);
    send_cmd(1'b0, 2'd2, 'h010, 4);
    load_words(2'd2, 'h010, 4, 1'b0, 1'b1, 'hA0, 1);
    check("load_done_pulse", {30'h0, bus.done, bus.done_aborted}, 32'h2);
    cyc();
    check("load_cmd_ready_back", 32'(bus.cmd_ready), 32'h1);

    // Preload bank 1 across the wrap point, then STORE it back with m_ready high
    exp_done_q.push_back(1'b0);
    send_cmd(1'b0, 2'd1, 'h3FE, 4);
    load_words(2'd1, 'h3FE, 4, 1'b0, 1'b1, 'h11, 'h11);
    wait_idle();
    m_ready_force = 1'b1;
    cyc();
    exp_done_q.push_back(1'b0);
    expect_store(2'd1, 'h3FE, 4, 4);
    send_cmd(1'b1, 2'd1, 'h3FE, 4);
    check("store_lat_c1", 32'(bus.m_valid), 32'h0);
    cyc();
    check("store_lat_c2", 32'(bus.m_valid), 32'h0);
    cyc();
    check("store_lat_c3", {15'h0, bus.m_valid, bus.m_data}, 32'h10011);
    wait_idle();

    // STORE len 8 under backpressure: only four reads fit before the FIFO fills
    m_ready_force = 1'b0;
    cyc();
    rs0 = reads_seen;
    exp_done_q.push_back(1'b0);
    expect_store(2'd3, 100, 8, 8);
    send_cmd(1'b1, 2'd3, 100, 8);
    cyc(9);
    check("bp_reads_issued", 32'(reads_seen - rs0), 32'h4);
    check("bp_head_held", {15'h0, bus.m_valid, bus.m_data}, {15'h0, 1'b1, ref_mem[3*BD + 100]});
    m_ready_force = 1'b1;
    wait_idle();

    // Zero-length command
    exp_done_q.push_back(1'b0);
    send_cmd(1'b0, 2'd0, 5, 0);
    check("len0_done", {30'h0, bus.done, bus.done_aborted}, 32'h2);
    check("len0_no_mem", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    cyc();
    check("len0_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    // STORE len 16 aborted on the third read cycle
    m_ready_force = 1'b0;
    cyc();
    rs0 = reads_seen;
    exp_done_q.push_back(1'b1);
    expect_store(2'd2, 'h200, 3, 0);
    send_cmd(1'b1, 2'd2, 'h200, 16);
    cyc(2);
    check("abort_third_read", 32'(bus.mem_read), 32'h1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_next_cycle", {29'h0, bus.mem_read, bus.m_valid, bus.s_ready}, 32'h0);
    cyc();
    check("abort_discard", 32'(bus.m_valid), 32'h0);
    wait_idle();
    check("abort_reads_total", 32'(reads_seen - rs0), 32'h3);
    check("abort_fifo_empty", 32'(bus.m_valid), 32'h0);
    m_ready_force = 1'b1;

    // Reset in the middle of a 6-word LOAD
    send_cmd(1'b0, 2'd0, 'h300, 6);
    load_words(2'd0, 'h300, 2, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cyc(2);
    rst_n = 1'b1;
    cyc();
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    exp_done_q.push_back(1'b0);
    send_cmd(1'b0, 2'd0, 'h300, 6);
    load_words(2'd0, 'h300, 6, 1'b1, 1'b0, 0, 0);
    wait_idle();

    // Random mix of LOAD/STORE bursts, biased toward the bank wrap point
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      bit dir;
      logic [1:0] bank;
      int addr, len;
      dir  = 1'($urandom_range(0, 1));
      bank = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
      len  = $urandom_range(0, 12);
      exp_done_q.push_back(1'b0);
      if (dir) begin
        expect_store(bank, addr, len, len);
        send_cmd(1'b1, bank, addr, len);
      end else begin
        send_cmd(1'b0, bank, addr, len);
        load_words(bank, addr, len, 1'b1, 1'b0, 0, 0);
      end
      wait_idle();
    end
    rand_ready = 1'b0;
    m_ready_force = 1'b1;
    cyc(5);

    check("writes_outstanding", 32'(exp_wr_q.size()), 32'h0);
    check("reads_outstanding", 32'(exp_rd_q.size()), 32'h0);
    check("words_outstanding", 32'(exp_m_q.size()), 32'h0);
    check("dones_outstanding", 32'(exp_done_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cgra_tile_dma.md
Name: cgra_tile_dma

Overview:
DMA initiator that drives the external access port of the row-banked CGRA tile memory.
- Host→tile (LOAD): moves a burst of words from a valid/ready input stream into one bank.
- Tile→host (STORE): moves a burst from one bank to a valid/ready output stream, through a small credit-controlled FIFO that absorbs the memory's 1-cycle read latency and downstream backpressure.
- Sits between the system-side data mover/host and the tile memory's ext_* port.

Parameters:
DATA_WIDTH, 16, word width; matches tile memory.
ADDR_WIDTH, 12, per-bank address width.
BANK_DEPTH, 1024, entries per bank; address wrap point.
LEN_WIDTH, 13, burst length field width, in words.
FIFO_DEPTH, 4, STORE-path output FIFO entries; power of 2, ≥2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_dir  in  1  0 = LOAD (host→tile), 1 = STORE (tile→host)
cmd_bank  in  2  target bank
cmd_addr  in  ADDR_WIDTH  start address; must be < BANK_DEPTH
cmd_len  in  LEN_WIDTH  word count; 0 is legal
abort  in  1  terminate the active burst
s_valid / s_ready / s_data  in/out/in  1/1/DATA_WIDTH  LOAD input stream
m_valid / m_ready / m_data  out/in/out  1/1/DATA_WIDTH  STORE output stream
mem_addr  out  ADDR_WIDTH  to ext_addr
mem_bank_sel  out  2  to ext_bank_sel
mem_read  out  1  to ext_read
mem_write  out  1  to ext_write
mem_wdata  out  DATA_WIDTH  to ext_wdata
mem_rdata  in  DATA_WIDTH  from ext_rdata
mem_valid  in  1  from ext_valid; asserted 1 cycle after mem_read
busy  out  1  high whenever state ≠ IDLE
done  out  1  1-cycle completion pulse
done_aborted  out  1  qualifies done; 1 = burst was aborted

Behaviour:
- Async reset: state IDLE, all counters 0, FIFO empty, in-flight flag 0, done and done_aborted 0. Outputs: cmd_ready=1 (state-derived), all other outputs 0.
- States:
  - IDLE: cmd_valid && cmd_ready latches dir/bank/addr/len. len=0 → DONE. Otherwise → LOAD or STORE.
  - LOAD: s_ready=1. mem_write=s_valid, mem_wdata=s_data, mem_addr=cur_addr. Each s handshake increments addr and decrements remaining. Last handshake → DONE. Throughput 1 word/cycle.
  - STORE: mem_read=1 when remaining>0 && (fifo_count + inflight) < FIFO_DEPTH. Each issue increments addr and decrements remaining, and sets inflight for one cycle. mem_valid while inflight pushes mem_rdata into the FIFO. Issuing stops when remaining=0 → DRAIN.
  - DRAIN: no new reads. Exits to DONE when inflight=0 && FIFO empty.
  - DONE: done=1 for exactly one cycle → IDLE. cmd_ready returns the following cycle.
- mem_* outputs are combinational from state/registers. They are 0 outside LOAD/STORE. mem_read and mem_write are never asserted together. mem_bank_sel holds the latched bank for the whole burst.
- Address wrap: cur_addr == BANK_DEPTH-1 increments to 0. Bank is unchanged.
- STORE latency: accept at cycle 0 → mem_read at cycle 1 → FIFO push at the end of cycle 2 → m_valid at cycle 3.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_valid/m_data are held stable until m_ready.
  - With m_ready held high, sustained rate is 1 word/cycle.
- Simultaneous FIFO push and pop in the same cycle: count unchanged, data order preserved.
- Credit rule guarantees no FIFO overflow. mem_valid with inflight=0 is ignored.
- Abort, in LOAD or STORE:
  - Next cycle: no new mem_read/mem_write; s_ready=0; FIFO flushed.
  - A read still in flight is discarded on return.
  - → DRAIN → DONE with done_aborted=1.
  - abort in IDLE, DRAIN or DONE is ignored.
- done_aborted is 0 on normal completion.
- cmd_valid outside IDLE is not accepted and not queued.
- Reset mid-burst: immediate return to IDLE; FIFO contents and any in-flight read are lost. No done pulse.

Test Plan:
- LOAD bank 2, addr 0x010, len 4, s_valid held with data 0xA0..0xA3 → mem_write 4 consecutive cycles at 0x010..0x013 with bank_sel=2, then done=1 and done_aborted=0 one cycle after the last write.
- STORE bank 1, addr 0x3FE, len 4, memory preloaded with 0x11,0x22,0x33,0x44 at 0x3FE,0x3FF,0x000,0x001 → addresses wrap to 0 after 0x3FF; m_data sequence is 0x11,0x22,0x33,0x44; first m_valid 3 cycles after command accept.
- STORE len 8 with m_ready low for cycles 3–10 → mem_read stops after 4 issues with FIFO full; no data lost or reordered; all 8 words delivered once m_ready rises.
- cmd_len=0 → no mem_read/mem_write asserted; done pulses 1 cycle after accept; cmd_ready high the cycle after that.
- STORE len 16, abort asserted on the 3rd mem_read cycle → no further reads; FIFO flushed; done=1 with done_aborted=1; busy=0 afterwards.
- rst_n low mid-LOAD at word 2 of 6 → all outputs return to reset values immediately; cmd_ready=1 after release; a new LOAD completes normally.
